// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one single-cycle ALU through a
// round-robin IDLE/EXEC sequencer with a one-deep response register per
// requester. The alu datapath module lives in this file as well.

module alu (
  input  logic [31:0] i_opA,
  input  logic [31:0] i_opB,
  input  logic [4:0]  i_opcode,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_result,
  output logic [2:0]  o_flags
);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_addOv;
  logic        w_subOv;

  assign w_sum   = i_opA + i_opB;
  assign w_diff  = i_opA - i_opB;
  assign w_addOv = (i_opA[31] == i_opB[31]) && (w_sum[31] != i_opA[31]);
  assign w_subOv = (i_opA[31] != i_opB[31]) && (w_diff[31] != i_opA[31]);

  // Result mux and flags; only add/sub report overflow, only sub compares
  always_comb begin
    o_result = 32'd0;
    o_flags  = 3'b000;
    case (i_opcode)
      OP_ADD: begin
        o_result = w_sum;
        o_flags  = {w_addOv, 2'b00};
      end
      OP_SUB: begin
        o_result = w_diff;
        o_flags  = {w_subOv, w_diff[31] ^ w_subOv, |w_diff};
      end
      OP_AND: o_result = i_opA & i_opB;
      OP_OR:  o_result = i_opA | i_opB;
      OP_SLL: o_result = i_opA << i_shamt;
      OP_SRA: o_result = $signed(i_opA) >>> i_shamt;
      default: begin
        o_result = 32'd0;
        o_flags  = 3'b000;
      end
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int unsigned INIT_PRIO = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_opA_0,
  input  logic [31:0] req_opA_1,
  input  logic [31:0] req_opB_0,
  input  logic [31:0] req_opB_1,
  input  logic [4:0]  req_opcode_0,
  input  logic [4:0]  req_opcode_1,
  input  logic [4:0]  req_shamt_0,
  input  logic [4:0]  req_shamt_1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result_0,
  output logic [31:0] rsp_result_1,
  output logic [2:0]  rsp_flags_0,
  output logic [2:0]  rsp_flags_1,
  output logic        busy
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_ptr;
  logic        r_grant;
  logic [31:0] r_opA;
  logic [31:0] r_opB;
  logic [4:0]  r_opcode;
  logic [4:0]  r_shamt;
  logic [1:0]  r_rspValid;
  logic [31:0] r_result0;
  logic [31:0] r_result1;
  logic [2:0]  r_flags0;
  logic [2:0]  r_flags1;

  logic [1:0]  w_free;
  logic [1:0]  w_elig;
  logic [1:0]  w_reqReady;
  logic        w_take;
  logic        w_takeIdx;
  logic [31:0] w_aluResult;
  logic [2:0]  w_aluFlags;

  // A slot is free when empty or being drained this cycle; while reset is
  // held nobody is eligible so no handshake is advertised.
  assign w_free = ~r_rspValid | rsp_ready;
  assign w_elig = req_valid & w_free & {2{reset}};

  assign w_take    = |(req_valid & w_reqReady);
  assign w_takeIdx = w_reqReady[1];

  assign req_ready    = w_reqReady;
  assign rsp_valid    = r_rspValid;
  assign rsp_result_0 = r_result0;
  assign rsp_result_1 = r_result1;
  assign rsp_flags_0  = r_flags0;
  assign rsp_flags_1  = r_flags1;
  assign busy         = (r_state == EXEC);

  alu u_alu (
    .i_opA    (r_opA),
    .i_opB    (r_opB),
    .i_opcode (r_opcode),
    .i_shamt  (r_shamt),
    .o_result (w_aluResult),
    .o_flags  (w_aluFlags)
  );

  // Next-state and grant selection; the pointer breaks ties only
  always_comb begin
    w_nextState = r_state;
    w_reqReady  = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_elig == 2'b11) begin
          w_reqReady = r_ptr ? 2'b10 : 2'b01;
        end else begin
          w_reqReady = w_elig;
        end
        if (|w_reqReady) begin
          w_nextState = EXEC;
        end
      end
      EXEC: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Latch the granted operands and owner, and hand priority to the other side
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_opA    <= 32'd0;
      r_opB    <= 32'd0;
      r_opcode <= 5'd0;
      r_shamt  <= 5'd0;
      r_grant  <= 1'b0;
      r_ptr    <= INIT_PRIO[0];
    end else if (w_take) begin
      r_opA    <= w_takeIdx ? req_opA_1    : req_opA_0;
      r_opB    <= w_takeIdx ? req_opB_1    : req_opB_0;
      r_opcode <= w_takeIdx ? req_opcode_1 : req_opcode_0;
      r_shamt  <= w_takeIdx ? req_shamt_1  : req_shamt_0;
      r_grant  <= w_takeIdx;
      r_ptr    <= ~w_takeIdx;
    end
  end

  // Response slots: drain on rsp_ready, fill from the ALU at the end of EXEC
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rspValid <= 2'b00;
      r_result0  <= 32'd0;
      r_result1  <= 32'd0;
      r_flags0   <= 3'b000;
      r_flags1   <= 3'b000;
    end else begin
      if (r_rspValid[0] && rsp_ready[0]) begin
        r_rspValid[0] <= 1'b0;
      end
      if (r_rspValid[1] && rsp_ready[1]) begin
        r_rspValid[1] <= 1'b0;
      end
      if (r_state == EXEC) begin
        if (r_grant == 1'b0) begin
          r_rspValid[0] <= 1'b1;
          r_result0     <= w_aluResult;
          r_flags0      <= w_aluFlags;
        end else begin
          r_rspValid[1] <= 1'b1;
          r_result1     <= w_aluResult;
          r_flags1      <= w_aluFlags;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes hand-computed responses
// into per-requester queues, a negedge monitor pops them as responses drain.

module tb_alu_arbiter;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;

  logic        clock;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_opA_0, req_opA_1, req_opB_0, req_opB_1;
  logic [4:0]  req_opcode_0, req_opcode_1, req_shamt_0, req_shamt_1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result_0, rsp_result_1;
  logic [2:0]  rsp_flags_0, rsp_flags_1;
  logic        busy;

  int nVectors = 0;
  int nMiscompares = 0;

  logic [34:0] q0[$];
  logic [34:0] q1[$];
  logic [34:0] e0, e1;

  logic [31:0] pendA   [2];
  logic [31:0] pendB   [2];
  logic [4:0]  pendOpc [2];
  logic [4:0]  pendSh  [2];
  logic [31:0] pendRes [2];
  logic [2:0]  pendFlg [2];
  logic [34:0] curExp  [2];

  alu_arbiter #(.INIT_PRIO(0)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opA_0    (req_opA_0),
    .req_opA_1    (req_opA_1),
    .req_opB_0    (req_opB_0),
    .req_opB_1    (req_opB_1),
    .req_opcode_0 (req_opcode_0),
    .req_opcode_1 (req_opcode_1),
    .req_shamt_0  (req_shamt_0),
    .req_shamt_1  (req_shamt_1),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result_0 (rsp_result_0),
    .rsp_result_1 (rsp_result_1),
    .rsp_flags_0  (rsp_flags_0),
    .rsp_flags_1  (rsp_flags_1),
    .busy         (busy)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Queue the operation requester k presents from its next applied cycle
  task automatic setOp(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] opc, input logic [4:0] sh,
                       input logic [31:0] res, input logic [2:0] flg);
    pendA[k]   = a;
    pendB[k]   = b;
    pendOpc[k] = opc;
    pendSh[k]  = sh;
    pendRes[k] = res;
    pendFlg[k] = flg;
  endtask

  // One cycle: drive inputs just after posedge, check comb outputs, and
  // record the expected response of every handshake about to happen
  task automatic applyStimulus(input logic rst, input logic [1:0] valid,
                               input logic [1:0] rdy, input logic [1:0] expReady,
                               input logic expBusy, input logic push,
                               input string tag);
    @(posedge clock);
    #1;
    reset        = rst;
    req_valid    = valid;
    rsp_ready    = rdy;
    req_opA_0    = pendA[0];
    req_opB_0    = pendB[0];
    req_opcode_0 = pendOpc[0];
    req_shamt_0  = pendSh[0];
    req_opA_1    = pendA[1];
    req_opB_1    = pendB[1];
    req_opcode_1 = pendOpc[1];
    req_shamt_1  = pendSh[1];
    curExp[0]    = {pendFlg[0], pendRes[0]};
    curExp[1]    = {pendFlg[1], pendRes[1]};
    #1;
    checkOutput({tag, "_req_ready"}, {30'd0, req_ready}, {30'd0, expReady});
    checkOutput({tag, "_busy"}, {31'd0, busy}, {31'd0, expBusy});
    if (push && req_valid[0] && req_ready[0]) q0.push_back(curExp[0]);
    if (push && req_valid[1] && req_ready[1]) q1.push_back(curExp[1]);
  endtask

  // Monitor: each response that drains at the coming posedge is scored
  always @(negedge clock) begin
    if (reset) begin
      if (rsp_valid[0] && rsp_ready[0]) begin
        if (q0.size() == 0) begin
          nVectors++;
          nMiscompares++;
          $display("[TB] FAIL rsp0_unexpected: got result 0x%08h, expected no response", rsp_result_0);
        end else begin
          e0 = q0.pop_front();
          checkOutput("rsp0_result", rsp_result_0, e0[31:0]);
          checkOutput("rsp0_flags", {29'd0, rsp_flags_0}, {29'd0, e0[34:32]});
        end
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
        if (q1.size() == 0) begin
          nVectors++;
          nMiscompares++;
          $display("[TB] FAIL rsp1_unexpected: got result 0x%08h, expected no response", rsp_result_1);
        end else begin
          e1 = q1.pop_front();
          checkOutput("rsp1_result", rsp_result_1, e1[31:0]);
          checkOutput("rsp1_flags", {29'd0, rsp_flags_1}, {29'd0, e1[34:32]});
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    nMiscompares++;
    $display("[TB] FAIL watchdog: got timeout, expected normal completion");
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    reset = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_opA_0 = '0; req_opB_0 = '0; req_opcode_0 = '0; req_shamt_0 = '0;
    req_opA_1 = '0; req_opB_1 = '0; req_opcode_1 = '0; req_shamt_1 = '0;
    setOp(0, 32'd0, 32'd0, OP_ADD, 5'd0, 32'd0, 3'b000);
    setOp(1, 32'd0, 32'd0, OP_ADD, 5'd0, 32'd0, 3'b000);

    $display("[TB] reset with both requesters valid");
    applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, "rst_a");
    applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, "rst_b");
    checkOutput("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    checkOutput("rst_result0", rsp_result_0, 32'd0);
    checkOutput("rst_result1", rsp_result_1, 32'd0);
    checkOutput("rst_flags0", {29'd0, rsp_flags_0}, 32'd0);
    checkOutput("rst_flags1", {29'd0, rsp_flags_1}, 32'd0);

    $display("[TB] first grant and single requester latency");
    setOp(0, 32'd5, 32'd7, OP_ADD, 5'd0, 32'd12, 3'b000);
    setOp(1, 32'h0000_00F0, 32'h0000_000F, OP_OR, 5'd0, 32'h0000_00FF, 3'b000);
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b01, 1'b0, 1'b1, "first_grant");
    applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, "single_exec");
    checkOutput("single_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    applyStimulus(1'b1, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, "single_rsp");
    checkOutput("single_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, "single_drained");
    checkOutput("single_drained_valid", {30'd0, rsp_valid}, 32'd0);

    $display("[TB] round robin with both requesters");
    setOp(0, 32'd3, 32'd9, OP_SUB, 5'd0, 32'hFFFF_FFFA, 3'b011);
    applyStimulus(1'b1, 2'b11, 2'b11, 2'b10, 1'b0, 1'b1, "rr_0");
    applyStimulus(1'b1, 2'b11, 2'b11, 2'b00, 1'b1, 1'b1, "rr_1");
    applyStimulus(1'b1, 2'b11, 2'b11, 2'b01, 1'b0, 1'b1, "rr_2");
    applyStimulus(1'b1, 2'b11, 2'b11, 2'b00, 1'b1, 1'b1, "rr_3");
    applyStimulus(1'b1, 2'b11, 2'b11, 2'b10, 1'b0, 1'b1, "rr_4");
    applyStimulus(1'b1, 2'b11, 2'b11, 2'b00, 1'b1, 1'b1, "rr_5");

    $display("[TB] backpressure on requester 1, overflow and shifts on requester 0");
    setOp(0, 32'h7FFF_FFFF, 32'd1, OP_ADD, 5'd0, 32'h8000_0000, 3'b100);
    applyStimulus(1'b1, 2'b11, 2'b01, 2'b01, 1'b0, 1'b1, "bp_0");
    checkOutput("bp_0_rsp_valid", {30'd0, rsp_valid}, 32'd2);
    checkOutput("bp_0_hold1", rsp_result_1, 32'h0000_00FF);
    setOp(0, 32'd1, 32'd0, OP_SLL, 5'd31, 32'h8000_0000, 3'b000);
    applyStimulus(1'b1, 2'b11, 2'b01, 2'b00, 1'b1, 1'b1, "bp_1");
    checkOutput("bp_1_hold1", rsp_result_1, 32'h0000_00FF);
    applyStimulus(1'b1, 2'b11, 2'b01, 2'b01, 1'b0, 1'b1, "bp_2");
    checkOutput("bp_2_rsp_valid", {30'd0, rsp_valid}, 32'd3);
    setOp(0, 32'h8000_0000, 32'd0, OP_SRA, 5'd4, 32'hF800_0000, 3'b000);
    applyStimulus(1'b1, 2'b11, 2'b01, 2'b00, 1'b1, 1'b1, "bp_3");
    applyStimulus(1'b1, 2'b11, 2'b01, 2'b01, 1'b0, 1'b1, "bp_4");
    checkOutput("bp_4_hold1", rsp_result_1, 32'h0000_00FF);
    checkOutput("bp_4_hold1_flags", {29'd0, rsp_flags_1}, 32'd0);
    applyStimulus(1'b1, 2'b11, 2'b01, 2'b00, 1'b1, 1'b1, "bp_5");
    setOp(1, 32'd5, 32'd5, OP_SUB, 5'd0, 32'd0, 3'b000);
    applyStimulus(1'b1, 2'b11, 2'b11, 2'b10, 1'b0, 1'b1, "bp_release");
    applyStimulus(1'b1, 2'b00, 2'b11, 2'b00, 1'b1, 1'b1, "bp_exec");
    applyStimulus(1'b1, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1, "bp_tail");

    $display("[TB] subtract with signed overflow");
    setOp(1, 32'h8000_0000, 32'd1, OP_SUB, 5'd0, 32'h7FFF_FFFF, 3'b111);
    applyStimulus(1'b1, 2'b10, 2'b11, 2'b10, 1'b0, 1'b1, "subov");
    applyStimulus(1'b1, 2'b00, 2'b11, 2'b00, 1'b1, 1'b1, "subov_exec");
    applyStimulus(1'b1, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1, "subov_rsp");

    $display("[TB] reset during EXEC");
    setOp(0, 32'd1, 32'd2, OP_ADD, 5'd0, 32'd3, 3'b000);
    applyStimulus(1'b1, 2'b01, 2'b11, 2'b01, 1'b0, 1'b0, "mid_grant");
    applyStimulus(1'b0, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, "mid_exec_rst");
    applyStimulus(1'b0, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, "mid_hold");
    checkOutput("mid_hold_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    setOp(0, 32'hFF00_FF00, 32'h0FF0_0FF0, OP_AND, 5'd0, 32'h0F00_0F00, 3'b000);
    setOp(1, 32'd1, 32'd2, OP_OR, 5'd0, 32'd3, 3'b000);
    applyStimulus(1'b1, 2'b11, 2'b11, 2'b01, 1'b0, 1'b1, "post_rst_grant");
    checkOutput("post_rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    applyStimulus(1'b1, 2'b00, 2'b11, 2'b00, 1'b1, 1'b1, "post_exec");
    checkOutput("post_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    applyStimulus(1'b1, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1, "post_rsp");
    checkOutput("post_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    applyStimulus(1'b1, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1, "drain_0");
    applyStimulus(1'b1, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1, "drain_1");
    checkOutput("q0_left", q0.size(), 32'd0);
    checkOutput("q1_left", q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
